record_snare: RTL and testbench

// - Capture-side counterpart to the sample playback readers: records 8-bit unsigned ADC/mic samples at the
//   8 kHz sample strobe into on-chip RAM, storing them two's-complement (sample - 128, i.e. MSB flipped).
// - Provides a synchronous read port that restores unsigned format (+128) so playback/DAC logic reuses the clip.
// - Sits between the ADC sample register and the drum-voice playback path; software/buttons arm and stop it.

---
 rtl/record_snare.sv | 117 +++++++++++
 tb/tb_record_snare.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/record_snare.sv
// Sample recorder: captures unsigned 8-bit samples on the strobe into RAM as two's-complement
// and plays them back unsigned. Optional level trigger enabled by defining REC_TRIGGER_EN.
module record_snare #(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned AW     = 12,
  parameter int unsigned THRESH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          arm,
  input  logic          stop,
  input  logic [7:0]    sample_in,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          busy,
  output logic          done,
  output logic          full,
  output logic [AW:0]   length
);

  typedef enum logic [1:0] {StIdle, StArmed, StRecord, StDone} state_t;

  state_t         state;
  logic [7:0]     mem [DEPTH];
  logic [7:0]     s;
  logic [AW-1:0]  wr_addr;
  logic           we;
  logic           last;

  assign s       = sample_in ^ 8'h80;
  // length doubles as the write pointer; it is 0 in ARMED so the trigger sample lands at 0
  assign wr_addr = length[AW-1:0];
  assign last    = (length == (AW+1)'(DEPTH - 1));

`ifdef REC_TRIGGER_EN
  logic [8:0] mag;
  logic       trig;

  // 9-bit magnitude so that -128 reads as 128
  assign mag  = s[7] ? (9'd256 - {1'b0, s}) : {1'b0, s};
  assign trig = (mag >= 9'(THRESH));
  assign we   = en && ((state == StRecord) || ((state == StArmed) && trig && !stop));
`else
  assign we   = en && (state == StRecord);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= StIdle;
      busy   <= 1'b0;
      done   <= 1'b0;
      full   <= 1'b0;
      length <= '0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          if (arm) begin
            length <= '0;
            full   <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b1;
`ifdef REC_TRIGGER_EN
            state  <= StArmed;
`else
            state  <= StRecord;
`endif
          end
        end
`ifdef REC_TRIGGER_EN
        StArmed: begin
          if (stop) begin
            state <= StDone;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (en && trig) begin
            length <= (AW+1)'(1);
            state  <= StRecord;
          end
        end
`endif
        StRecord: begin
          if (en) begin
            length <= length + 1'b1;
          end
          if ((en && last) || stop) begin
            state <= StDone;
            busy  <= 1'b0;
            done  <= 1'b1;
            full  <= en && last;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= s;
    end
  end

  // Registered read; same-address write in this cycle is seen next cycle (read-before-write)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= 8'h80;
    end else begin
      rd_data <= mem[rd_addr] + 8'h80;
    end
  end

endmodule

// File: tb/tb_record_snare.sv
// Directed bench for record_snare with a read-data scoreboard queue.
module tb_record_snare;

  localparam int unsigned DEPTH  = 4096;
  localparam int unsigned AW     = 12;
  localparam int unsigned THRESH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          arm;
  logic          stop;
  logic [7:0]    sample_in;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy;
  logic          done;
  logic          full;
  logic [AW:0]   length;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q [$];

  record_snare #(.DEPTH(DEPTH), .AW(AW), .THRESH(THRESH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .arm       (arm),
    .stop      (stop),
    .sample_in (sample_in),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .full      (full),
    .length    (length)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_status(input string tag, input logic b, input logic d, input logic f,
                              input int unsigned len);
    check({tag, ".busy"}, 16'(busy), 16'(b));
    check({tag, ".done"}, 16'(done), 16'(d));
    check({tag, ".full"}, 16'(full), 16'(f));
    check({tag, ".length"}, 16'(length), 16'(len));
  endtask

  task automatic pulse_arm();
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic strobe(input logic [7:0] smp, input logic with_stop);
    @(negedge clk);
    en        = 1'b1;
    sample_in = smp;
    stop      = with_stop;
    @(negedge clk);
    en        = 1'b0;
    stop      = 1'b0;
  endtask

  // Push the expected value when the address is driven, pop when the data comes out
  task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [7:0] expv);
    logic [7:0] e;
    @(negedge clk);
    rd_addr = a;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check(tag, 16'(rd_data), 16'(e));
  endtask

  logic [7:0] first5 [5];

  initial begin
    first5[0] = 8'h90; first5[1] = 8'h00; first5[2] = 8'hFF; first5[3] = 8'h80;
    first5[4] = 8'h7F;
    rst = 1'b0; en = 1'b0; arm = 1'b0; stop = 1'b0; sample_in = 8'h00; rd_addr = '0;

    // Reset values while held in reset
    repeat (3) @(negedge clk);
    check_status("reset", 1'b0, 1'b0, 1'b0, 0);
    check("reset.rd_data", 16'(rd_data), 16'h0080);
    rst = 1'b1;

    // Basic capture, no trigger
`ifndef REC_TRIGGER_EN
    pulse_arm();
    check_status("arm1", 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 5; i++) strobe(first5[i], 1'b0);
    check_status("cap5", 1'b1, 1'b0, 1'b0, 5);
    pulse_stop();
    check_status("stop5", 1'b0, 1'b1, 1'b0, 5);
    strobe(8'h11, 1'b0);
    check_status("done_en", 1'b0, 1'b1, 1'b0, 5);
    for (int i = 0; i < 5; i++) read_check($sformatf("rd5_%0d", i), AW'(i), first5[i]);
`else
    // Trigger capture: 8'h85 (|s|=5) skipped, 8'h70 (s=-16) triggers
    pulse_arm();
    check_status("tarm", 1'b1, 1'b0, 1'b0, 0);
    strobe(8'h85, 1'b0);
    check_status("t85", 1'b1, 1'b0, 1'b0, 0);
    strobe(8'h70, 1'b0);
    check_status("t70", 1'b1, 1'b0, 1'b0, 1);
    strobe(8'h90, 1'b0);
    strobe(8'hA0, 1'b0);
    check_status("tA0", 1'b1, 1'b0, 1'b0, 3);
    pulse_stop();
    check_status("tstop", 1'b0, 1'b1, 1'b0, 3);
    read_check("trd0", AW'(0), 8'h70);
    read_check("trd1", AW'(1), 8'h90);
    read_check("trd2", AW'(2), 8'hA0);
    pulse_arm();
    strobe(8'h8F, 1'b0);
    pulse_stop();
    check_status("tarmed_stop", 1'b0, 1'b1, 1'b0, 0);
`endif

    // stop together with en at length 7; arm in RECORD ignored
    pulse_arm();
`ifdef REC_TRIGGER_EN
    for (int i = 0; i < 7; i++) strobe(8'hC0 + 8'(i), 1'b0);
`else
    for (int i = 0; i < 7; i++) strobe(8'h20 + 8'(i), 1'b0);
`endif
    check_status("len7", 1'b1, 1'b0, 1'b0, 7);
    strobe(8'h42, 1'b1);
    check_status("stop_en", 1'b0, 1'b1, 1'b0, 8);
    read_check("rd_stop_en", AW'(7), 8'h42);
    pulse_arm();
    check_status("rearm", 1'b1, 1'b0, 1'b0, 0);

    // Reset mid-capture at length 10
`ifdef REC_TRIGGER_EN
    strobe(8'hF0, 1'b0);
    for (int i = 1; i < 10; i++) strobe(8'(i * 3 + 1), 1'b0);
`else
    strobe(8'h30, 1'b0);
    strobe(8'h31, 1'b0);
    pulse_arm();
    check_status("arm_ignored", 1'b1, 1'b0, 1'b0, 2);
    for (int i = 2; i < 10; i++) strobe(8'(i * 3 + 1), 1'b0);
`endif
    check_status("len10", 1'b1, 1'b0, 1'b0, 10);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_status("midreset", 1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b1;
`ifdef REC_TRIGGER_EN
    read_check("keep0", AW'(0), 8'hF0);
`else
    read_check("keep0", AW'(0), 8'h30);
    read_check("keep1", AW'(1), 8'h31);
`endif
    for (int i = 2; i < 10; i++) read_check($sformatf("keep%0d", i), AW'(i), 8'(i * 3 + 1));

    // Fill to DEPTH, then extra strobes must not write or count
    pulse_arm();
    for (int i = 0; i < DEPTH + 3; i++) begin
      if (i == 0) strobe(8'hF5, 1'b0);
      else if (i < DEPTH) strobe(8'(i), 1'b0);
      else strobe(8'hEE, 1'b0);
      if (i == DEPTH - 2) check_status("fill_m1", 1'b1, 1'b0, 1'b0, DEPTH - 1);
      if (i == DEPTH - 1) check_status("fill", 1'b0, 1'b1, 1'b1, DEPTH);
    end
    check_status("fill_after", 1'b0, 1'b1, 1'b1, DEPTH);
    read_check("full_rd0", AW'(0), 8'hF5);
    read_check("full_rd1", AW'(1), 8'h01);
    read_check("full_rdlast", AW'(DEPTH - 1), 8'hFF);
    pulse_arm();
    check_status("arm_after_full", 1'b1, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
